// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side engine for a synchronous data FIFO with a
// fixed read latency. Words are popped while credit exists, landed in a
// small skid buffer, and presented downstream as a valid/ready stream.
//
// Handshake: a beat transfers on any rising clk edge where m_tvalid and
// m_tready are both high. Once m_tvalid is raised it stays high, and m_tdata
// stays unchanged, until that transfer happens. m_tvalid never depends on
// m_tready.
module fifo_stream_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_re,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  idle
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // Wide enough for count + inflight even if the credit check were broken.
  localparam int CW = $clog2(BUF_DEPTH + READ_LATENCY + 1);

  logic [READ_LATENCY-1:0] rd_pipe;
  logic [CW-1:0]           count;
  logic [CW-1:0]           inflight;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [DATA_WIDTH-1:0]   buf_mem [BUF_DEPTH];
  logic                    capture;
  logic                    pop;

  // Number of reads issued whose data has not yet landed in the buffer.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CW'(rd_pipe[i]);
    end
  end

  // Issue only from registered state, so a word always has a slot to land in.
  assign fifo_re  = !rst && !fifo_empty && ((count + inflight) < CW'(BUF_DEPTH));
  assign capture  = rd_pipe[READ_LATENCY-1];
  assign m_tvalid = (count != '0);
  assign pop      = m_tvalid && m_tready;
  assign m_tdata  = buf_mem[rd_ptr];
  assign idle     = (count == '0) && (inflight == '0);

  // Read-valid pipeline: tracks each issued read until its data appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | READ_LATENCY'(fifo_re);
    end
  end

  // Skid-buffer storage: land returning words at the write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (capture) begin
      buf_mem[wr_ptr] <= fifo_dout;
    end
  end

  // Pointers and occupancy; capture and pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credit invariants: outstanding words never exceed the buffer size.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(capture && !pop && (count == CW'(BUF_DEPTH))));
  a_credit: assert property (@(posedge clk) disable iff (rst)
    (count + inflight) <= CW'(BUF_DEPTH));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a behavioural FIFO with a two-cycle read
// latency feeds the reader, and a scoreboard checks every stream beat.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int RL = 2;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_re;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          idle;

  logic          push_v = 1'b0;
  logic [DW-1:0] push_d = '0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] p1 = '0;
  logic [DW-1:0] exp_q[$];
  int            beat_cyc_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int re_cnt = 0;

  // Clock
  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH  (DW),
    .READ_LATENCY(RL),
    .BUF_DEPTH   (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_re   (fifo_re),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .idle      (idle)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // FIFO model: sync reset shared with the reader, two-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      fifo_q.delete();
      p1         <= '0;
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_re && fifo_q.size() != 0) p1 <= fifo_q.pop_front();
      if (push_v) fifo_q.push_back(push_d);
      fifo_dout  <= p1;
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: checks issue against empty and scores every accepted beat.
  always @(negedge clk) begin
    if (fifo_re) begin
      re_cnt++;
      chk("re_while_empty", fifo_empty, 0);
    end
    if (m_tvalid && m_tready && !rst) begin
      beat_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
      else chk("beat_data", m_tdata, exp_q.pop_front());
    end
  end

  // Watchdog
  initial begin
    repeat (60000) @(posedge clk);
    bad++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    push_v = 1'b1;
    push_d = w;
    exp_q.push_back(w);
    step();
    push_v = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic check_gapfree(input string tag, input int nbeats);
    chk({tag, "_beats"}, beat_cyc_q.size(), nbeats);
    if (beat_cyc_q.size() == nbeats)
      chk({tag, "_spread"}, beat_cyc_q[nbeats-1] - beat_cyc_q[0], nbeats - 1);
  endtask

  initial begin
    int r0;
    int t_re;
    int t_v;
    int k;
    int left;
    int guard;

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("rst_re", fifo_re, 0);
    chk("rst_valid", m_tvalid, 0);
    chk("rst_data", m_tdata, 0);
    chk("rst_idle", idle, 1);

    // Test 1: eight words, ready held high, gap-free output
    m_tready = 1'b1;
    beat_cyc_q.delete();
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    drain("t1_drain", 50);
    check_gapfree("t1", 8);
    step();
    chk("t1_idle", idle, 1);

    // Test 2: sixteen words with ready low, then release
    m_tready = 1'b0;
    r0 = re_cnt;
    for (int i = 0; i < 16; i++) push_word(32'h0000_0200 + DW'(i));
    repeat (10) step();
    chk("t2_re_pulses", re_cnt - r0, BD);
    chk("t2_valid", m_tvalid, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold", m_tdata, 32'h0000_0200);
      step();
    end
    m_tready = 1'b1;
    drain("t2_drain", 100);
    step();
    chk("t2_idle", idle, 1);

    // Test 3: random ready and random push gaps over 1000 words
    left = 1000;
    guard = 0;
    while (left > 0 && guard < 20000) begin
      m_tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        push_word($urandom);
        left--;
      end else begin
        step();
      end
      guard++;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 10000) begin
      m_tready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    chk("t3_drain", exp_q.size(), 0);
    m_tready = 1'b1;
    repeat (4) step();
    chk("t3_idle", idle, 1);

    // Test 4: single word latency from issue to valid
    m_tready = 1'b0;
    r0 = re_cnt;
    push_word(32'hDEAD_BEEF);
    k = 0;
    while (!fifo_re && k < 20) begin
      step();
      k++;
    end
    chk("t4_re_seen", fifo_re, 1);
    t_re = cyc;
    k = 0;
    while (!m_tvalid && k < 20) begin
      step();
      k++;
    end
    t_v = cyc;
    chk("t4_latency", t_v - t_re, RL + 1);
    chk("t4_data", m_tdata, 32'hDEAD_BEEF);
    chk("t4_re_pulses", re_cnt - r0, 1);
    m_tready = 1'b1;
    step();
    chk("t4_idle", idle, 1);
    chk("t4_drain", exp_q.size(), 0);

    // Test 5: reset with words buffered and in flight
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h0000_0500 + DW'(i));
    k = 0;
    while (!m_tvalid && k < 20) begin
      step();
      k++;
    end
    step();
    chk("t5_busy", idle, 0);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    chk("t5_valid", m_tvalid, 0);
    chk("t5_idle", idle, 1);
    chk("t5_data", m_tdata, 0);
    m_tready = 1'b1;
    repeat (8) step();
    chk("t5_quiet", m_tvalid, 0);
    push_word(32'h1234_5678);
    drain("t5_drain", 50);
    step();
    chk("t5_idle_end", idle, 1);

    // Test 6: sustained stream across pointer wrap
    m_tready = 1'b1;
    beat_cyc_q.delete();
    for (int i = 0; i < 3 * BD; i++) push_word(32'hA5A5_0000 + DW'(i * 7));
    drain("t6_drain", 60);
    check_gapfree("t6", 3 * BD);
    step();
    chk("t6_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
